// File: rtl/mandel_pkg.sv
// Shared types and helpers for the Mandelbrot line scheduler.
// Holds the scheduler state encoding and the reorder-slot index mapping.
// No ports; imported by the scheduler and its reorder buffer.
package mandel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_DRAIN,
        ST_NEXT_LINE
    } sched_state_t;

    // Slot for pixel x. Slot counts are powers of two, so a mask is enough.
    function automatic int unsigned slot_idx(input int unsigned x, input int unsigned depth);
        return x & (depth - 1);
    endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: ROB_DEPTH result slots with per-slot valid bits.
// Latency: writes/clears visible the cycle after; the read port is combinational.
// Backpressure: none; the owner keeps writers off slots that are still valid.
// Ports: NUM_PORTS write ports (wr_en/wr_idx/wr_dat), one clear port, one read port.
module reorder_buffer #(
    parameter int NUM_PORTS = 5,
    parameter int DEPTH_W   = 10,
    parameter int ROB_DEPTH = 16,
    localparam int IDX_W    = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_PORTS-1:0]           wr_en,
    input  logic [NUM_PORTS*IDX_W-1:0]     wr_idx,
    input  logic [NUM_PORTS*DEPTH_W-1:0]   wr_dat,
    input  logic                           clr_en,
    input  logic [IDX_W-1:0]               clr_idx,
    input  logic [IDX_W-1:0]               rd_idx,
    output logic                           rd_vld,
    output logic [DEPTH_W-1:0]             rd_dat
);

    logic [DEPTH_W-1:0]   mem_q [ROB_DEPTH];
    logic [DEPTH_W-1:0]   mem_d [ROB_DEPTH];
    logic [ROB_DEPTH-1:0] vld_q;
    logic [ROB_DEPTH-1:0] vld_d;

    always_comb begin
        mem_d = mem_q;
        vld_d = vld_q;
        if (clr_en) begin
            vld_d[clr_idx] = 1'b0;
        end
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (wr_en[p]) begin
                mem_d[wr_idx[p*IDX_W +: IDX_W]] = wr_dat[p*DEPTH_W +: DEPTH_W];
                vld_d[wr_idx[p*IDX_W +: IDX_W]] = 1'b1;
            end
        end
    end

    // Data needs no reset: it is only consumed behind a valid bit.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign rd_vld = vld_q[rd_idx];
    assign rd_dat = mem_q[rd_idx];

endmodule

// File: rtl/mandel_line_scheduler.sv
// Pixel scheduler: issues x to idle depth engines, reorders results, streams them in raster order.
// Latency: frame_start -> first eng_start 2 cycles; head eng_done -> out_valid 2 cycles.
// Backpressure: out_* hold while out_valid && !out_ready; dispatch stalls when the ROB is full.
// Ports: frame_start/mode control; eng_start/eng_x/eng_y issue and eng_done/eng_depth results;
//        out_valid/out_ready stream with out_x/out_y/out_depth/out_eol/out_eof; busy, run_done.
module mandel_line_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES   = 5,
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int DEPTH_W       = 10,
    parameter int ROB_DEPTH     = 16,
    parameter int X_W           = $clog2(SCREEN_WIDTH),
    parameter int Y_W           = $clog2(SCREEN_HEIGHT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           frame_start,
    input  logic                           mode,
    output logic [NUM_ENGINES-1:0]         eng_start,
    output logic [NUM_ENGINES*X_W-1:0]     eng_x,
    output logic [Y_W-1:0]                 eng_y,
    input  logic [NUM_ENGINES-1:0]         eng_done,
    input  logic [NUM_ENGINES*DEPTH_W-1:0] eng_depth,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [X_W-1:0]                 out_x,
    output logic [Y_W-1:0]                 out_y,
    output logic [DEPTH_W-1:0]             out_depth,
    output logic                           out_eol,
    output logic                           out_eof,
    output logic                           busy,
    output logic                           run_done
);

    localparam int IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
    localparam int P_W   = X_W + 1;
    localparam logic [P_W-1:0] LINE_END = P_W'(SCREEN_WIDTH);
    localparam logic [P_W-1:0] LAST_X   = P_W'(SCREEN_WIDTH - 1);
    localparam logic [Y_W-1:0] LAST_Y   = Y_W'(SCREEN_HEIGHT - 1);
    localparam logic [31:0]    ROB_LIM  = ROB_DEPTH;

    sched_state_t               state_q, state_d;
    logic                       mode_q, mode_d;
    logic [Y_W-1:0]             y_q, y_d;
    logic [P_W-1:0]             dx_q, dx_d;
    logic [P_W-1:0]             hx_q, hx_d;
    logic [NUM_ENGINES-1:0]     eng_busy_q, eng_busy_d;
    logic [NUM_ENGINES-1:0]     eng_start_q, eng_start_d;
    logic [NUM_ENGINES*X_W-1:0] eng_x_q, eng_x_d;
    logic                       out_valid_q, out_valid_d;
    logic [X_W-1:0]             out_x_q, out_x_d;
    logic [DEPTH_W-1:0]         out_depth_q, out_depth_d;
    logic                       out_eol_q, out_eol_d;
    logic                       out_eof_q, out_eof_d;
    logic                       run_done_q, run_done_d;

    logic                       handshake;
    logic [P_W-1:0]             next_hx;
    logic [P_W-1:0]             in_flight;
    logic                       can_issue;
    logic                       issued;
    logic [NUM_ENGINES*IDX_W-1:0] rob_wr_idx;
    logic [IDX_W-1:0]           rob_clr_idx;
    logic [IDX_W-1:0]           rob_rd_idx;
    logic                       rob_rd_vld;
    logic [DEPTH_W-1:0]         rob_rd_dat;

    assign handshake   = out_valid_q && out_ready;
    // Output register preloads the pixel after the one being accepted, keeping one pixel per cycle.
    assign next_hx     = handshake ? hx_q + 1'b1 : hx_q;
    assign in_flight   = dx_q - hx_q;
    assign rob_clr_idx = IDX_W'(slot_idx(32'(hx_q), ROB_DEPTH));
    assign rob_rd_idx  = IDX_W'(slot_idx(32'(next_hx), ROB_DEPTH));
    assign can_issue   = (state_q == ST_DISPATCH) && (dx_q != LINE_END)
                         && ({{(32-P_W){1'b0}}, in_flight} < ROB_LIM);

    // Results land in the slot of the x the engine was started with (old x, even if reissued now).
    always_comb begin
        rob_wr_idx = '0;
        for (int i = 0; i < NUM_ENGINES; i++) begin
            rob_wr_idx[i*IDX_W +: IDX_W] = IDX_W'(slot_idx(32'(eng_x_q[i*X_W +: X_W]), ROB_DEPTH));
        end
    end

    reorder_buffer #(
        .NUM_PORTS (NUM_ENGINES),
        .DEPTH_W   (DEPTH_W),
        .ROB_DEPTH (ROB_DEPTH)
    ) u_rob (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (eng_done & eng_busy_q),
        .wr_idx  (rob_wr_idx),
        .wr_dat  (eng_depth),
        .clr_en  (handshake),
        .clr_idx (rob_clr_idx),
        .rd_idx  (rob_rd_idx),
        .rd_vld  (rob_rd_vld),
        .rd_dat  (rob_rd_dat)
    );

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        y_d         = y_q;
        dx_d        = dx_q;
        hx_d        = handshake ? hx_q + 1'b1 : hx_q;
        eng_busy_d  = eng_busy_q & ~eng_done;
        eng_start_d = '0;
        eng_x_d     = eng_x_q;
        run_done_d  = 1'b0;
        issued      = 1'b0;

        // Lowest-index engine that is idle, or is finishing this cycle, takes the next x.
        for (int i = 0; i < NUM_ENGINES; i++) begin
            if (can_issue && !issued && (!eng_busy_q[i] || eng_done[i])) begin
                issued                  = 1'b1;
                eng_start_d[i]          = 1'b1;
                eng_busy_d[i]           = 1'b1;
                eng_x_d[i*X_W +: X_W]   = dx_q[X_W-1:0];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    mode_d  = mode;
                    y_d     = '0;
                    dx_d    = '0;
                    hx_d    = '0;
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (issued) begin
                    dx_d = dx_q + 1'b1;
                    if (dx_q + 1'b1 == LINE_END) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (handshake && out_eol_q) begin
                    if (out_eof_q) begin
                        run_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        state_d    = ST_NEXT_LINE;
                    end
                end
            end
            ST_NEXT_LINE: begin
                y_d     = y_q + 1'b1;
                dx_d    = '0;
                hx_d    = '0;
                state_d = ST_DISPATCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_x_d     = out_x_q;
        out_depth_d = out_depth_q;
        out_eol_d   = out_eol_q;
        out_eof_d   = out_eof_q;
        if (!(out_valid_q && !out_ready)) begin
            // With a single slot the accepted pixel's slot is the one being cleared: not yet refilled.
            out_valid_d = ((state_q == ST_DISPATCH) || (state_q == ST_DRAIN))
                          && (next_hx < LINE_END) && rob_rd_vld
                          && !(handshake && (rob_rd_idx == rob_clr_idx));
            out_x_d     = next_hx[X_W-1:0];
            out_depth_d = rob_rd_dat;
            out_eol_d   = (next_hx == LAST_X);
            out_eof_d   = (next_hx == LAST_X) && (!mode_q || (y_q == LAST_Y));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            mode_q      <= 1'b0;
            y_q         <= '0;
            dx_q        <= '0;
            hx_q        <= '0;
            eng_busy_q  <= '0;
            eng_start_q <= '0;
            eng_x_q     <= '0;
            out_valid_q <= 1'b0;
            out_x_q     <= '0;
            out_depth_q <= '0;
            out_eol_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            hx_q        <= hx_d;
            eng_busy_q  <= eng_busy_d;
            eng_start_q <= eng_start_d;
            eng_x_q     <= eng_x_d;
            out_valid_q <= out_valid_d;
            out_x_q     <= out_x_d;
            out_depth_q <= out_depth_d;
            out_eol_q   <= out_eol_d;
            out_eof_q   <= out_eof_d;
            run_done_q  <= run_done_d;
        end
    end

    assign eng_start = eng_start_q;
    assign eng_x     = eng_x_q;
    assign eng_y     = y_q;
    assign out_valid = out_valid_q;
    assign out_x     = out_x_q;
    assign out_y     = y_q;
    assign out_depth = out_depth_q;
    assign out_eol   = out_eol_q;
    assign out_eof   = out_eof_q;
    assign busy      = (state_q != ST_IDLE);
    assign run_done  = run_done_q;

endmodule
